ascon_perm_ctrl: RTL

- Iterative ASCON permutation engine and sequencer. Loads a 320-bit state (x0..x4), then applies N rounds at one round per clock.
- Each round is: round-constant addition into x2, 5-bit S-box layer, then the existing linear diffusion layer.
- Sits between the mode-level controller (init/AD/encrypt/finalize sequencing) and the round datapath. Owns the round counter, the constant schedule and the state register.

---
 rtl/ascon_pkg.sv | 49 ++++
 rtl/ascon_round.sv | 46 ++++
 rtl/ascon_perm_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: state layout, S-box truth table, round constants
// and the controller FSM encoding.
package ascon_pkg;

   localparam int LANE_W  = 64;
   localparam int N_LANES = 5;
   localparam int STATE_W = LANE_W * N_LANES;

   // Lane 0 (x0) occupies the most significant 64 bits of the packed state.
   typedef logic [0:N_LANES-1][LANE_W-1:0] state_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } fsm_t;

   // Indexed by the column {x0[i],x1[i],x2[i],x3[i],x4[i]}; result uses the same bit order.
   localparam logic [0:31][4:0] SBOX = {
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   // Constant for schedule index 0..11: F0, E1, D2, ... 5A, 4B.
   function automatic logic [7:0] round_const(input logic [3:0] idx);
      return {4'hF - idx, idx};
   endfunction

   function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] x, input int unsigned amt);
      logic [2*LANE_W-1:0] dbl;
      dbl = {x, x} >> amt;
      return dbl[LANE_W-1:0];
   endfunction

   function automatic state_t unpack_state(input logic [STATE_W-1:0] flat);
      return state_t'(flat);
   endfunction

   function automatic logic [STATE_W-1:0] pack_state(input state_t st);
      return STATE_W'(st);
   endfunction

   function automatic logic [LANE_W-1:0] get_lane(input state_t st, input int unsigned idx);
      return st[idx];
   endfunction

endpackage

// File: rtl/ascon_round.sv
// One ASCON round, purely combinational: constant addition into x2,
// bitsliced 5-bit S-box layer, then the per-lane linear diffusion layer.
module ascon_round
   import ascon_pkg::*;
(
   input  state_t     st_in,
   input  logic [7:0] rc,
   output state_t     st_out
);

   state_t     st_c;
   state_t     st_s;
   logic [4:0] col_in;
   logic [4:0] col_out;

   always_comb begin
      st_c          = st_in;
      st_c[2][7:0]  = st_in[2][7:0] ^ rc;
   end

   always_comb begin
      st_s    = '0;
      col_in  = '0;
      col_out = '0;
      for (int i = 0; i < LANE_W; i++) begin
         col_in     = {st_c[0][i], st_c[1][i], st_c[2][i], st_c[3][i], st_c[4][i]};
         col_out    = SBOX[col_in];
         st_s[0][i] = col_out[4];
         st_s[1][i] = col_out[3];
         st_s[2][i] = col_out[2];
         st_s[3][i] = col_out[1];
         st_s[4][i] = col_out[0];
      end
   end

   // Each lane is mixed only with rotated copies of itself.
   always_comb begin
      st_out    = '0;
      st_out[0] = st_s[0] ^ rotr(st_s[0], 19) ^ rotr(st_s[0], 28);
      st_out[1] = st_s[1] ^ rotr(st_s[1], 61) ^ rotr(st_s[1], 39);
      st_out[2] = st_s[2] ^ rotr(st_s[2], 1)  ^ rotr(st_s[2], 6);
      st_out[3] = st_s[3] ^ rotr(st_s[3], 10) ^ rotr(st_s[3], 17);
      st_out[4] = st_s[4] ^ rotr(st_s[4], 7)  ^ rotr(st_s[4], 41);
   end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative ASCON permutation sequencer: accepts a state, runs the tail of the
// constant schedule one round per clock, and holds the result until taken.
module ascon_perm_ctrl
   import ascon_pkg::*;
#(
   parameter int MAX_ROUNDS = 12,
   parameter int CNT_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CNT_W-1:0]   rounds,
   input  logic [STATE_W-1:0] s_in,
   input  logic               abort,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] s_out,
   output logic               busy
);

   localparam logic [CNT_W-1:0] MAX_R  = CNT_W'(MAX_ROUNDS);
   localparam logic [CNT_W-1:0] LAST_R = CNT_W'(MAX_ROUNDS - 1);

   fsm_t             fsm_q, fsm_d;
   state_t           st_q, st_d;
   state_t           st_rnd;
   logic [CNT_W-1:0] ridx_q, ridx_d;
   logic [CNT_W-1:0] n_eff;
   logic [3:0]       ridx4;

   assign n_eff = (rounds > MAX_R) ? MAX_R : rounds;
   assign ridx4 = 4'(ridx_q);

   ascon_round u_round (
      .st_in  (st_q),
      .rc     (round_const(ridx4)),
      .st_out (st_rnd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= S_IDLE;
         st_q   <= '0;
         ridx_q <= '0;
      end else begin
         fsm_q  <= fsm_d;
         st_q   <= st_d;
         ridx_q <= ridx_d;
      end
   end

   always_comb begin
      fsm_d  = fsm_q;
      st_d   = st_q;
      ridx_d = ridx_q;
      case (fsm_q)
         S_IDLE: begin
            // abort has no meaning here, a simultaneous request is still taken
            if (in_valid) begin
               st_d   = unpack_state(s_in);
               ridx_d = MAX_R - n_eff;
               fsm_d  = (n_eff == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (abort) begin
               st_d   = '0;
               ridx_d = '0;
               fsm_d  = S_IDLE;
            end else begin
               st_d = st_rnd;
               if (ridx_q == LAST_R) begin
                  ridx_d = '0;
                  fsm_d  = S_DONE;
               end else begin
                  ridx_d = ridx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            if (abort) begin
               st_d   = '0;
               ridx_d = '0;
               fsm_d  = S_IDLE;
            end else if (out_ready) begin
               fsm_d = S_IDLE;
            end
         end
         default: begin
            st_d   = '0;
            ridx_d = '0;
            fsm_d  = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (fsm_q == S_IDLE);
   assign busy      = (fsm_q == S_RUN);
   assign out_valid = (fsm_q == S_DONE);
   assign s_out     = pack_state(st_q);

endmodule
